// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station and the issue stage that consumes it:
// the station entry, the CDB broadcast, and helpers for clearing and operand snooping.
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

package reservation_station_pkg;

  localparam int RS_SIZE = `RS_SIZE;
  localparam int TAG_W   = 4;
  localparam int ID_W    = $clog2(RS_SIZE);
  localparam int CNT_W   = $clog2(RS_SIZE + 1);
  localparam int CTRL_W  = 8;
  localparam int NUM_CDB = 2;

  typedef struct packed {
    logic              busy;
    logic [ID_W-1:0]   id;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  tag_1;
    logic [TAG_W-1:0]  tag_2;
    logic [31:0]       value_1;
    logic [31:0]       value_2;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl_bits;
  } rs_entry;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
  } cdb_bus;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
  } rs_operand;

  // Empty entry; the id field is the slot's fixed position and survives clears.
  function automatic rs_entry rs_clear_entry(input logic [ID_W-1:0] slot);
    rs_entry e;
    e    = '0;
    e.id = slot;
    return e;
  endfunction

  // Tag 0 means "no producer", so it never matches; bus 0 wins a double match.
  function automatic rs_operand rs_snoop_operand(input rs_operand op,
                                                 input cdb_bus [NUM_CDB-1:0] cdb);
    rs_operand r;
    r = op;
    if (op.tag != '0) begin
      if (cdb[0].valid && (cdb[0].tag == op.tag)) begin
        r.tag   = '0;
        r.value = cdb[0].value;
      end else if (cdb[1].valid && (cdb[1].tag == op.tag)) begin
        r.tag   = '0;
        r.value = cdb[1].value;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_priority_encoder.sv
// Lowest-index free slot finder over a busy vector; also used by the issue stage.
module rs_priority_encoder
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] busy_i,
  output logic [ID_W-1:0]    free_idx_o,
  output logic               any_free_o
);

  // Scanning downward lets the lowest free index be the last one written.
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        free_idx_o = ID_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation-station array: dispatch into the lowest free slot, CDB wakeup with
// dispatch bypass, issue-driven free and flush. All outputs come from registered state.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  input  rs_entry                       dispatch_entry,
  output logic                          dispatch_ready,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB-1:0][31:0]      cdb_value,
  input  logic                          issue_valid,
  input  logic [ID_W-1:0]               issue_rs_id,
  output rs_entry                       res_stations [RS_SIZE],
  output logic [CNT_W-1:0]              count
);

  rs_entry                entries_q [RS_SIZE];
  rs_entry                entries_d [RS_SIZE];
  logic [RS_SIZE-1:0]     busy_vec;
  logic [ID_W-1:0]        free_idx;
  logic                   any_free;
  cdb_bus [NUM_CDB-1:0]   cdb;
  rs_entry                new_entry;
  rs_operand              op_1;
  rs_operand              op_2;

  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb[k].valid = cdb_valid[k];
      cdb[k].tag   = cdb_tag[k];
      cdb[k].value = cdb_value[k];
    end
  end

  always_comb begin
    busy_vec = '0;
    count    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i] = entries_q[i].busy;
      count       = count + {{(CNT_W-1){1'b0}}, entries_q[i].busy};
    end
  end

  rs_priority_encoder u_free_sel (
    .busy_i     (busy_vec),
    .free_idx_o (free_idx),
    .any_free_o (any_free)
  );

  // Handshake: a dispatch is accepted on a rising edge when dispatch_valid and
  // dispatch_ready are both high; dispatch_ready depends only on registered busy bits,
  // so a slot freed by issue this cycle is offered no earlier than the next cycle.
  assign dispatch_ready = any_free;

  always_comb begin
    entries_d = entries_q;
    op_1      = '0;
    op_2      = '0;
    new_entry = '0;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (entries_q[i].busy) begin
        op_1 = rs_snoop_operand({entries_q[i].tag_1, entries_q[i].value_1}, cdb);
        op_2 = rs_snoop_operand({entries_q[i].tag_2, entries_q[i].value_2}, cdb);
        entries_d[i].tag_1   = op_1.tag;
        entries_d[i].value_1 = op_1.value;
        entries_d[i].tag_2   = op_2.tag;
        entries_d[i].value_2 = op_2.value;
      end
    end

    // Issue of an idle slot is a protocol error and is ignored.
    if (issue_valid && entries_q[issue_rs_id].busy) begin
      entries_d[issue_rs_id].busy = 1'b0;
    end

    if (dispatch_valid && any_free) begin
      new_entry         = dispatch_entry;
      new_entry.busy    = 1'b1;
      new_entry.id      = free_idx;
      op_1 = rs_snoop_operand({dispatch_entry.tag_1, dispatch_entry.value_1}, cdb);
      op_2 = rs_snoop_operand({dispatch_entry.tag_2, dispatch_entry.value_2}, cdb);
      new_entry.tag_1   = op_1.tag;
      new_entry.value_1 = op_1.value;
      new_entry.tag_2   = op_2.tag;
      new_entry.value_2 = op_2.value;
      entries_d[free_idx] = new_entry;
    end

    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i] = rs_clear_entry(ID_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= rs_clear_entry(ID_W'(i));
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  assign res_stations = entries_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && !flush && issue_valid) begin
      assert (entries_q[issue_rs_id].busy)
        else $error("reservation_station: issue of idle slot %0d", issue_rs_id);
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wakeup, bypass, full/issue,
// flush and asynchronous reset, each checked against hand-computed values.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                          clk;
  logic                          reset;
  logic                          flush;
  logic                          dispatch_valid;
  rs_entry                       dispatch_entry;
  logic                          dispatch_ready;
  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag;
  logic [NUM_CDB-1:0][31:0]      cdb_value;
  logic                          issue_valid;
  logic [ID_W-1:0]               issue_rs_id;
  rs_entry                       res_stations [RS_SIZE];
  logic [CNT_W-1:0]              count;

  int checks;
  int errors;

  reservation_station dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_entry (dispatch_entry),
    .dispatch_ready (dispatch_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .issue_valid    (issue_valid),
    .issue_rs_id    (issue_rs_id),
    .res_stations   (res_stations),
    .count          (count)
  );

  // clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // busy/id are set to junk to confirm the station overrides them
  task automatic set_de(input logic [3:0] rob, input logic [3:0] t1, input logic [31:0] v1,
                        input logic [3:0] t2, input logic [31:0] v2, input logic [31:0] imm);
    dispatch_entry           = '0;
    dispatch_entry.busy      = 1'b0;
    dispatch_entry.id        = ID_W'(7);
    dispatch_entry.tag       = rob;
    dispatch_entry.tag_1     = t1;
    dispatch_entry.value_1   = v1;
    dispatch_entry.tag_2     = t2;
    dispatch_entry.value_2   = v2;
    dispatch_entry.imm       = imm;
    dispatch_entry.ctrl_bits = 8'h5A;
  endtask

  task automatic chk_all_idle(input string tag);
    for (int i = 0; i < RS_SIZE; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), 64'(res_stations[i].busy), 64'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_entry = '0;
    cdb_valid = '0;
    cdb_tag = '0;
    cdb_value = '0;
    issue_valid = 1'b0;
    issue_rs_id = '0;

    // reset state
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(dispatch_ready), 64'd1);
    chk("rst_id3", 64'(res_stations[3].id), 64'd3);
    chk("rst_id7", 64'(res_stations[7].id), 64'd7);
    chk_all_idle("rst");
    #10;
    reset = 1'b1;
    step();

    // three dispatches: A(0/0) B(3/0) C(5/6)
    dispatch_valid = 1'b1;
    set_de(4'd1, 4'd0, 32'h11, 4'd0, 32'h22, 32'h100);
    step();
    set_de(4'd2, 4'd3, 32'h0, 4'd0, 32'h33, 32'h200);
    step();
    set_de(4'd3, 4'd5, 32'h0, 4'd6, 32'h0, 32'h300);
    step();
    dispatch_valid = 1'b0;
    chk("disp3_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("disp3_busy%0d", i), 64'(res_stations[i].busy), 64'd1);
      chk($sformatf("disp3_id%0d", i), 64'(res_stations[i].id), 64'(i));
    end
    chk("disp3_busy3", 64'(res_stations[3].busy), 64'd0);
    chk("slot0_ready", 64'({res_stations[0].tag_1, res_stations[0].tag_2}), 64'd0);
    chk("slot0_v1", 64'(res_stations[0].value_1), 64'h11);
    chk("slot0_ctrl", 64'(res_stations[0].ctrl_bits), 64'h5A);
    chk("slot1_tag1", 64'(res_stations[1].tag_1), 64'd3);
    chk("slot2_tags", 64'({res_stations[2].tag_1, res_stations[2].tag_2}), 64'h56);

    // wake both operands of slot 2 from both buses
    cdb_valid = 2'b11;
    cdb_tag[0] = 4'd5; cdb_value[0] = 32'hAA;
    cdb_tag[1] = 4'd6; cdb_value[1] = 32'hBB;
    step();
    cdb_valid = 2'b00;
    chk("wake_tag1", 64'(res_stations[2].tag_1), 64'd0);
    chk("wake_tag2", 64'(res_stations[2].tag_2), 64'd0);
    chk("wake_v1", 64'(res_stations[2].value_1), 64'hAA);
    chk("wake_v2", 64'(res_stations[2].value_2), 64'hBB);
    chk("wake_other", 64'(res_stations[1].tag_1), 64'd3);

    // dispatch bypass from cdb1 into slot 3
    dispatch_valid = 1'b1;
    set_de(4'd4, 4'd7, 32'h0, 4'd0, 32'h55, 32'h400);
    cdb_valid = 2'b10;
    cdb_tag[1] = 4'd7; cdb_value[1] = 32'h1234;
    step();
    chk("byp_tag1", 64'(res_stations[3].tag_1), 64'd0);
    chk("byp_v1", 64'(res_stations[3].value_1), 64'h1234);
    chk("byp_v2", 64'(res_stations[3].value_2), 64'h55);

    // tag 0 on the bus never captures (slot 4)
    set_de(4'd5, 4'd0, 32'hCAFE, 4'd0, 32'h66, 32'h500);
    cdb_valid = 2'b01;
    cdb_tag[0] = 4'd0; cdb_value[0] = 32'hDEAD;
    step();
    chk("tag0_v1", 64'(res_stations[4].value_1), 64'hCAFE);
    chk("tag0_count", 64'(count), 64'd5);

    // both buses match: bus 0 wins (slot 5)
    set_de(4'd6, 4'd9, 32'h0, 4'd0, 32'h0, 32'h600);
    cdb_valid = 2'b11;
    cdb_tag[0] = 4'd9; cdb_value[0] = 32'h900;
    cdb_tag[1] = 4'd9; cdb_value[1] = 32'h901;
    step();
    cdb_valid = 2'b00;
    chk("both_v1", 64'(res_stations[5].value_1), 64'h900);

    // fill slots 6 and 7
    set_de(4'd7, 4'd0, 32'h7, 4'd0, 32'h7, 32'h700);
    step();
    set_de(4'd8, 4'd0, 32'h8, 4'd0, 32'h8, 32'h800);
    step();
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(dispatch_ready), 64'd0);

    // held request while full is ignored
    set_de(4'hF, 4'd0, 32'hF1, 4'd0, 32'hF2, 32'hF00);
    step();
    chk("held_count", 64'(count), 64'd8);
    chk("held_slot4", 64'(res_stations[4].tag), 64'd5);

    // cycle N: issue slot 4 while full, ready stays low
    issue_valid = 1'b1;
    issue_rs_id = ID_W'(4);
    #1;
    chk("issueN_ready", 64'(dispatch_ready), 64'd0);
    step();
    issue_valid = 1'b0;
    chk("issueN1_ready", 64'(dispatch_ready), 64'd1);
    chk("issueN1_count", 64'(count), 64'd7);
    chk("issueN1_busy4", 64'(res_stations[4].busy), 64'd0);
    step();
    dispatch_valid = 1'b0;
    chk("land_busy4", 64'(res_stations[4].busy), 64'd1);
    chk("land_tag4", 64'(res_stations[4].tag), 64'hF);
    chk("land_id4", 64'(res_stations[4].id), 64'd4);
    chk("land_imm4", 64'(res_stations[4].imm), 64'hF00);
    chk("land_count", 64'(count), 64'd8);

    // down to 5 busy, then flush against a dispatch
    issue_valid = 1'b1;
    issue_rs_id = ID_W'(7);
    step();
    issue_rs_id = ID_W'(6);
    step();
    issue_rs_id = ID_W'(5);
    step();
    issue_valid = 1'b0;
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1;
    dispatch_valid = 1'b1;
    set_de(4'd9, 4'd2, 32'h0, 4'd0, 32'h0, 32'h900);
    step();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ready", 64'(dispatch_ready), 64'd1);
    chk("flush_id2", 64'(res_stations[2].id), 64'd2);
    chk("flush_v1_2", 64'(res_stations[2].value_1), 64'd0);
    chk_all_idle("flush");

    // reset mid-stream clears before the next edge
    dispatch_valid = 1'b1;
    set_de(4'd1, 4'd0, 32'h1, 4'd0, 32'h2, 32'h3);
    step();
    step();
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_id1", 64'(res_stations[1].id), 64'd1);
    chk_all_idle("async");
    dispatch_valid = 1'b0;
    #2;
    reset = 1'b1;
    step();
    chk("post_rst_count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Holds the reservation-station array that feeds the combinational issue stage. Each cycle the issue stage picks the lowest-index ready entry from this array.
- Accepts one dispatched instruction per cycle into the lowest free slot.
- Wakes up waiting operands from two common-data-bus (CDB) broadcasts.
- Frees the slot named by the issue stage's rs_id. Flushes everything on a mispredict.

Parameters:
- RS_SIZE, 8, number of entries; the same value as the `RS_SIZE macro.
- TAG_W, 4, width of ROB/source tags. Tag value 0 means "operand ready / no producer".
- ID_W, $clog2(RS_SIZE), width of the slot id.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all entries.
- dispatch_valid  input  1  a dispatch request is present this cycle.
- dispatch_entry  input  rs_entry  the instruction to dispatch. The busy and id fields of this input are ignored.
- dispatch_ready  output  1  at least one slot is free (computed from registered state only).
- cdb_valid  input  2  per-bus broadcast valid.
- cdb_tag  input  2 x TAG_W  per-bus producer tag.
- cdb_value  input  2 x 32  per-bus result value.
- issue_valid  input  1  the issue stage consumed an entry this cycle.
- issue_rs_id  input  ID_W  id of the consumed entry.
- res_stations  output  rs_entry [RS_SIZE]  registered array, fed directly to the issue stage.
- count  output  $clog2(RS_SIZE+1)  number of busy entries.

Behaviour:
- Reset (reset==0, asynchronous), and flush==1 on a clock edge:
  - every entry is cleared: busy=0, all tags=0, values/imm/ctrl_bits=0.
  - the id field is not cleared: entry i holds id=i permanently, from reset onward.
  - count=0, dispatch_ready=1.
  - flush overrides dispatch, CDB and issue in the same cycle.
- Free-slot select: lowest index i with busy==0, taken from the current registered state.
  - dispatch_ready = OR of all ~busy.
  - A slot freed by issue this cycle is not visible until the next cycle. A full array stays not-ready for the cycle in which it issues.
- Dispatch: when dispatch_valid && dispatch_ready, the selected slot loads dispatch_entry with busy=1 and id=slot index.
  - dispatch_valid && !dispatch_ready: the request is ignored and no state changes. Upstream must hold the request until ready.
- Dispatch bypass: if dispatch_entry.tag_1 (or tag_2) is nonzero and equals cdb_tag[k] with cdb_valid[k]=1 in the same cycle:
  - the slot stores value_k and tag=0 for that operand.
  - if both buses match, bus 0 wins.
- Wakeup: for every busy entry, operand n with nonzero tag_n matching a valid cdb_tag[k] captures cdb_value[k] into value_n and clears tag_n.
  - Both operands may wake in the same cycle, from the same or different buses.
  - A tag of 0 never matches.
  - A woken entry becomes visible to the issue stage the next cycle.
- Issue free: issue_valid clears busy of entry issue_rs_id. Its other fields may remain stale.
  - issue_valid on a non-busy entry is a protocol error. It has no effect and an assertion fires in simulation.
- Simultaneous dispatch and issue: both apply. They cannot target the same slot, because the dispatch slot was free in registered state.
- count = number of busy entries in registered state, updated every cycle. It holds at RS_SIZE when full.
- No combinational path from dispatch_valid, cdb_* or issue_* to res_stations or dispatch_ready. All outputs are registered or derived from registered state only.

Decomposition:
- Shared package (alongside the existing issue_execute_register/rs_entry definitions) holds:
  - rs_entry struct: busy, id, tag, tag_1, tag_2, value_1, value_2, imm, ctrl_bits.
  - RS_SIZE, TAG_W, the cdb_bus struct (valid, tag, value).
- One natural sub-module: rs_priority_encoder.
  - Takes an RS_SIZE-bit busy vector; outputs the lowest free index and an any_free flag.
  - Reused later by the issue stage.

Test Plan:
- Reset, then dispatch three entries (tags 0/0, 3/0, 5/6) on consecutive cycles:
  - slots 0, 1, 2 are busy with ids 0, 1, 2; count=3.
  - the issue stage sees slot 0 ready.
- Fill all 8 slots, hold dispatch_valid; issue_rs_id=4 in cycle N:
  - dispatch_ready=0 in cycle N.
  - in N+1, dispatch_ready=1 and the held entry lands in slot 4.
- Slot 2 waits on tags 5/6; drive cdb0 = tag 5 / value 0xAA and cdb1 = tag 6 / value 0xBB in the same cycle:
  - the next cycle shows tag_1=tag_2=0, value_1=0xAA, value_2=0xBB.
- Dispatch an entry with tag_1=7 while cdb1 broadcasts tag 7 / value 0x1234 in the same cycle:
  - the slot stores tag_1=0, value_1=0x1234.
- Dispatch with tag_1=0 while the CDB broadcasts tag 0:
  - no capture; value_1 keeps the dispatched value.
- With 5 busy entries, assert flush together with dispatch_valid:
  - all busy=0, count=0, the dispatch is dropped.
- Assert reset mid-stream: all busy clear asynchronously before the next edge.
